// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor, D = X - Y, one bit per clock.
// A single full-subtractor slice and a borrow flip-flop walk the operands LSB first.
// Operands and results use valid/ready handshakes, and every output is registered.
module serial_subtractor #(
    parameter int unsigned WIDTH    = 6,
    parameter bit          SATURATE = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] D,
    output logic             B_out,
    output logic             OVF
);

    localparam int unsigned CntW = $clog2(WIDTH);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_t;

    state_t           state;
    logic [WIDTH-1:0] x_sr;
    logic [WIDTH-1:0] y_sr;
    logic [WIDTH-2:0] res_sr;   // difference bits already produced, MSB-aligned
    logic             x_msb;    // operand sign bits, kept for the overflow flag
    logic             y_msb;
    logic             borrow;
    logic [CntW-1:0]  cnt;

    logic             d_bit;
    logic             b_next;
    logic [WIDTH-1:0] raw;
    logic             ovf_raw;
    logic [WIDTH-1:0] d_final;

    // Full-subtractor slice, plus result assembly for the final bit
    always_comb begin
        d_bit   = x_sr[0] ^ y_sr[0] ^ borrow;
        b_next  = (~x_sr[0] & y_sr[0]) | (~(x_sr[0] ^ y_sr[0]) & borrow);
        raw     = {d_bit, res_sr};
        ovf_raw = (x_msb != y_msb) & (raw[WIDTH-1] != x_msb);
        d_final = raw;
        if (SATURATE && ovf_raw) begin
            d_final = x_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end

    // Control FSM, datapath shift registers and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= StIdle;
            x_sr      <= '0;
            y_sr      <= '0;
            res_sr    <= '0;
            x_msb     <= 1'b0;
            y_msb     <= 1'b0;
            borrow    <= 1'b0;
            cnt       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            D         <= '0;
            B_out     <= 1'b0;
            OVF       <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (in_valid) begin
                        x_sr     <= X;
                        y_sr     <= Y;
                        x_msb    <= X[WIDTH-1];
                        y_msb    <= Y[WIDTH-1];
                        borrow   <= 1'b0;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= StShift;
                    end
                end
                StShift: begin
                    x_sr   <= x_sr >> 1;
                    y_sr   <= y_sr >> 1;
                    res_sr <= raw[WIDTH-1:1];
                    borrow <= b_next;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CntW'(WIDTH - 1)) begin
                        D         <= d_final;
                        B_out     <= b_next;
                        OVF       <= ovf_raw;
                        out_valid <= 1'b1;
                        state     <= StDone;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor.
// A saturating DUT and a wrapping DUT share the same stimulus.
// The expected results are queued at accept time and compared when the DUTs present a result.
module tb_serial_subtractor;

    localparam int unsigned W = 6;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [W-1:0] X;
    logic [W-1:0] Y;
    logic         out_ready;

    logic         in_ready_s, out_valid_s, b_s, ovf_s;
    logic [W-1:0] d_s;
    logic         in_ready_w, out_valid_w, b_w, ovf_w;
    logic [W-1:0] d_w;

    typedef struct {
        logic [W-1:0] d_sat;
        logic [W-1:0] d_wrap;
        logic         b;
        logic         ovf;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    serial_subtractor #(.WIDTH(W), .SATURATE(1'b1)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
        .X(X), .Y(Y), .out_valid(out_valid_s), .out_ready(out_ready),
        .D(d_s), .B_out(b_s), .OVF(ovf_s)
    );

    serial_subtractor #(.WIDTH(W), .SATURATE(1'b0)) dut_wrap (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w),
        .X(X), .Y(Y), .out_valid(out_valid_w), .out_ready(out_ready),
        .D(d_w), .B_out(b_w), .OVF(ovf_w)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t e;
        int xs, ys, diff;
        xs = int'($signed(x));
        ys = int'($signed(y));
        diff = xs - ys;
        e.d_wrap = diff[W-1:0];
        e.ovf = (diff > 31) || (diff < -32);
        e.b = (x < y);
        e.d_sat = e.ovf ? ((xs >= 0) ? 6'h1F : 6'h20) : e.d_wrap;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int guard = 0;
        while (!in_ready_s && guard < 50) begin
            tick();
            guard++;
        end
        check("ready_wait", in_ready_s, 1);
    endtask

    // One full transaction; hold = cycles of backpressure once the result is valid
    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input int hold);
        int   lat;
        exp_t e;
        wait_ready();
        X = x;
        Y = y;
        in_valid = 1'b1;
        sb.push_back(model(x, y));
        tick();
        in_valid = 1'b0;
        X = W'($urandom);
        Y = W'($urandom);
        lat = 0;
        while (!out_valid_s && lat < 20) begin
            check("busy_in_ready", in_ready_s, 0);
            tick();
            lat++;
        end
        check("latency", lat, W);
        check("wrap_valid", out_valid_w, 1);
        if (sb.size() == 0) begin
            check("sb_empty", 1, 0);
            return;
        end
        e = sb.pop_front();
        check("d_sat", d_s, e.d_sat);
        check("d_wrap", d_w, e.d_wrap);
        check("b_out", b_s, e.b);
        check("ovf", ovf_s, e.ovf);
        check("ovf_wrap", ovf_w, e.ovf);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            X = W'($urandom);
            Y = W'($urandom);
            tick();
            check("hold_valid", out_valid_s, 1);
            check("hold_in_ready", in_ready_s, 0);
            check("hold_d", d_s, e.d_sat);
            check("hold_b", b_s, e.b);
            check("hold_ovf", ovf_s, e.ovf);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("post_valid", out_valid_s, 0);
        check("post_in_ready", in_ready_s, 1);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        X = '0;
        Y = '0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_in_ready", in_ready_s, 1);
        check("rst_out_valid", out_valid_s, 0);
        check("rst_d", d_s, 0);
        check("rst_b", b_s, 0);
        check("rst_ovf", ovf_s, 0);

        send(6'd5, 6'd3, 0);
        send(6'd3, 6'd5, 0);
        send(6'h1F, 6'h3F, 0);
        send(6'h20, 6'h01, 10);
        send(6'd7, 6'h39, 2);
        for (int i = 0; i < 8; i++) send(W'($urandom), W'($urandom), i % 3);

        // Abort while the fourth bit is being computed
        wait_ready();
        X = 6'h1F;
        Y = 6'h3F;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_in_ready", in_ready_s, 1);
        check("abort_out_valid", out_valid_s, 0);
        check("abort_d", d_s, 0);
        check("abort_b", b_s, 0);
        check("abort_ovf", ovf_s, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("abort_no_out", out_valid_s, 0);
        end
        send(6'd10, 6'd10, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial two's-complement subtractor, D = X - Y, with a valid/ready handshake on both sides. It is the subtract counterpart of the team's 6-bit ripple adder. Variable-node LLR updates use it to remove a check-node message from a total LLR. It trades the combinational ripple chain for one full-subtractor slice plus a borrow flip-flop, so it processes one bit per clock.

Parameters:
WIDTH, 6, operand and result width in bits (minimum 2).
SATURATE, 1, 1 = clamp the signed result on overflow; 0 = wrap modulo 2^WIDTH.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
in_valid  input  1  X/Y operands valid
in_ready  output  1  block can accept operands
X  input  WIDTH  minuend, two's complement
Y  input  WIDTH  subtrahend, two's complement
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
D  output  WIDTH  difference (saturated if SATURATE=1)
B_out  output  1  unsigned borrow: 1 iff X < Y as unsigned values
OVF  output  1  signed overflow of the raw difference

Behaviour:
- Single clock domain, clk. Reset is synchronous and active-high on rst.
- Reset values: in_ready=1, out_valid=0, D=0, B_out=0, OVF=0. The FSM enters IDLE, the bit counter is 0 and the borrow flip-flop is 0.
- rst sampled high in any state (including mid-SHIFT or DONE) aborts the operation. The partial result is discarded and nothing is emitted.
- FSM states:
  - IDLE: in_ready=1, out_valid=0.
    - On in_valid & in_ready: capture X and Y into shift registers, clear the borrow flip-flop and bit counter, go to SHIFT.
  - SHIFT: in_ready=0, out_valid=0.
    - Each cycle: d_i = x_i XOR y_i XOR b; b_next = (~x_i & y_i) | (~(x_i XOR y_i) & b), LSB first.
    - Shift d_i into the result register.
    - After bit WIDTH-1: go to DONE.
  - DONE: out_valid=1, in_ready=0.
    - D, B_out and OVF hold stable until out_valid & out_ready.
    - On that handshake: go to IDLE (out_valid=0 and in_ready=1 from the next cycle).
- Latency:
  - Handshake accepted at edge E0; bits computed at edges E1..E_WIDTH; out_valid is high from edge E_WIDTH.
  - WIDTH=6: the result is valid 6 cycles after acceptance.
  - Minimum period between accepts is WIDTH+2 cycles.
- Operands are registered at acceptance. Changes to X/Y after that edge have no effect. in_valid while busy is ignored (no queuing).
- Result flags:
  - B_out is the final borrow flip-flop value.
  - OVF = (X[msb] != Y[msb]) & (raw[msb] != X[msb]).
- Saturation:
  - SATURATE=1 and OVF=1: D = 0 followed by WIDTH-1 ones (+2^(WIDTH-1)-1) if X is non-negative. D = 1 followed by WIDTH-1 zeros (-2^(WIDTH-1)) if X is negative.
  - Otherwise D = raw.
- D, B_out and OVF are registered outputs and only change on a transition into DONE or on reset. They keep the last result while in IDLE/SHIFT.
- No combinational path from any input to any output.

Test Plan:
- Basic subtract: reset, then X=5, Y=3, in_valid pulse. Required: out_valid rises exactly 6 cycles after accept; D=6'h02, B_out=0, OVF=0; in_ready=0 throughout SHIFT/DONE.
- Negative result: X=3, Y=5. Required: D=6'h3E (-2), B_out=1, OVF=0.
- Positive overflow: X=6'h1F (+31), Y=6'h3F (-1).
  - SATURATE=1: D=6'h1F, OVF=1, B_out=1.
  - SATURATE=0: D=6'h20, OVF=1.
- Negative overflow: X=6'h20 (-32), Y=6'h01.
  - SATURATE=1: D=6'h20, OVF=1, B_out=0.
  - SATURATE=0: D=6'h1F.
- Backpressure and busy input:
  - Hold out_ready=0 for 10 cycles in DONE. Required: D/B_out/OVF stable, in_ready=0, and a new X/Y with in_valid=1 is not accepted.
  - Raise out_ready. Required: handshake occurs; in_ready=1 next cycle; the next operands are accepted and give the correct result.
- Reset mid-operation: assert rst for one cycle at SHIFT bit 3. Required: next cycle in_ready=1, out_valid=0, D=0, B_out=0, OVF=0; a following X=10, Y=10 gives D=0, B_out=0, OVF=0 after 6 cycles.
